instr_fetch: RTL and testbench

Instruction fetch stage for the MIPS datapath, sitting directly upstream of the instruction RAM's read port. It owns the program counter, drives the RAM read address, absorbs the RAM's one-cycle synchronous read latency, and presents instruction/PC pairs to the decode stage over a valid/ready handshake. A single-entry skid register holds the in-flight word when decode stalls. Redirects from branch/jump resolution flush all in-flight state.

---
 rtl/instr_fetch_pkg.sv | 8 +
 rtl/instr_fetch_skid.sv | 30 +++
 rtl/instr_fetch.sv | 71 +++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared MIPS datapath constants: default bus widths, first fetch address after
// reset, and the NOP encoding decode uses for its bubble.
package instr_fetch_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RESET_PC   = 0;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/instr_fetch_skid.sv
// Single-entry skid register: loads a payload on stall, releases it on drain, flush wins.
// Zero-latency output of the held payload; full stays set until drain or flush.
module instr_fetch_skid #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, hides the RAM's 1-cycle read latency, one word per cycle.
// Decode stall parks the in-flight word in a one-entry skid; redirect flushes everything.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0]    pc_q;
  logic [ADDR_WIDTH-1:0]    req_pc;
  logic                     req_valid;
  logic                     issue;
  logic                     skid_full;
  logic                     skid_load;
  logic                     skid_drain;
  logic [PAYLOAD_WIDTH-1:0] skid_dout;

  assign mem_addr = redirect_valid ? redirect_pc : pc_q;

  // Issuing is only safe when the word coming back next cycle has somewhere to go.
  assign issue      = redirect_valid | instr_ready | (~skid_full & ~req_valid);
  assign skid_load  = req_valid & ~skid_full & ~instr_ready & ~redirect_valid;
  assign skid_drain = skid_full & instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= PC_INIT;
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else if (issue) begin
      pc_q      <= mem_addr + ADDR_WIDTH'(1);
      req_pc    <= mem_addr;
      req_valid <= 1'b1;
    end else begin
      req_valid <= 1'b0;
    end
  end

  instr_fetch_skid #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .load    (skid_load),
    .drain   (skid_drain),
    .din     ({mem_rdata, req_pc}),
    .full    (skid_full),
    .dout    (skid_dout)
  );

  assign instr_valid        = ~redirect_valid & (skid_full | req_valid);
  assign {instr, instr_pc}  = skid_full ? skid_dout : {mem_rdata, req_pc};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + random bench for instr_fetch against a sequential-PC stream model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  instr_pc;

  logic [31:0] ram [16];

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   exp_pc = 0;
  logic prev_hold = 1'b0;
  logic [3:0] prev_pc = '0;

  instr_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then check against the stream model.
  task automatic step(input logic rdy, input logic rv, input logic [3:0] rpc);
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (rv) begin
      chk("redirect_kills_valid", {31'b0, instr_valid}, 32'd0);
      exp_pc = int'(rpc);
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_pc", {28'b0, instr_pc}, {28'b0, prev_pc});
      end
      if (instr_valid && rdy) begin
        chk("accept_pc", {28'b0, instr_pc}, 32'(exp_pc));
        chk("accept_instr", instr, 32'(exp_pc + 100));
        exp_pc = (exp_pc + 1) % 16;
        n_acc++;
      end
    end
    prev_hold = !rv && instr_valid && !rdy;
    prev_pc   = instr_pc;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'(i + 100);
    reset_n        = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_mem_addr", {28'b0, mem_addr}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd7;
    #1;
    chk("reset_mem_addr_redirect", {28'b0, mem_addr}, 32'd7);
    redirect_valid = 1'b0;

    @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 0;
    #1;
    chk("release_cycle_valid", {31'b0, instr_valid}, 32'd0);

    // First word one cycle after release, then 1..15,0 back to back
    step(1'b1, 1'b0, 4'd0);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc", {28'b0, instr_pc}, 32'd0);
    chk("first_instr", instr, 32'd100);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 4'd0);
      chk("stream_valid", {31'b0, instr_valid}, 32'd1);
      chk("stream_pc", {28'b0, instr_pc}, 32'(i % 16));
    end

    // Stall three cycles while pc 4 is presented
    repeat (3) step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", {28'b0, instr_pc}, 32'd4);
      chk("stall_instr", instr, 32'd104);
    end
    step(1'b1, 1'b0, 4'd0);
    chk("release_pc", {28'b0, instr_pc}, 32'd4);
    step(1'b1, 1'b0, 4'd0);
    chk("after_stall_valid", {31'b0, instr_valid}, 32'd1);
    chk("after_stall_pc", {28'b0, instr_pc}, 32'd5);

    // Redirect while streaming
    step(1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b0, 4'd0);
    chk("redir_valid", {31'b0, instr_valid}, 32'd1);
    chk("redir_pc", {28'b0, instr_pc}, 32'd9);
    chk("redir_instr", instr, 32'd109);
    step(1'b1, 1'b0, 4'd0);
    chk("redir_next_pc", {28'b0, instr_pc}, 32'd10);

    // Redirect while HELD on pc 6
    step(1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    chk("held_pc6", {28'b0, instr_pc}, 32'd6);
    step(1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 4'd0);
    chk("held_redir_valid", {31'b0, instr_valid}, 32'd1);
    chk("held_redir_pc", {28'b0, instr_pc}, 32'd2);
    step(1'b0, 1'b0, 4'd0);
    chk("held_redir_stays", {28'b0, instr_pc}, 32'd2);
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    chk("held_redir_next", {28'b0, instr_pc}, 32'd3);

    // Asynchronous reset in the middle of a stall
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    chk("pre_reset_valid", {31'b0, instr_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_reset_addr", {28'b0, mem_addr}, 32'd0);
    prev_hold = 1'b0;
    repeat (2) @(negedge clk);
    instr_ready = 1'b1;
    reset_n     = 1'b1;
    exp_pc      = 0;
    step(1'b1, 1'b0, 4'd0);
    chk("restart_valid", {31'b0, instr_valid}, 32'd1);
    chk("restart_pc", {28'b0, instr_pc}, 32'd0);

    // Random backpressure: accepted stream must stay strictly sequential
    n_acc = 0;
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 4'd0);
    chk("random_accepts_seen", {31'b0, (n_acc > 50)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
